// File: rtl/hex_keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner: FSM state encoding,
// the row/column to hex key map and the column priority encoder.
package hex_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    // Keypad legend: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] key;
        key = 4'h0;
        case ({row, col})
            4'h0: key = 4'h1;
            4'h1: key = 4'h2;
            4'h2: key = 4'h3;
            4'h3: key = 4'hA;
            4'h4: key = 4'h4;
            4'h5: key = 4'h5;
            4'h6: key = 4'h6;
            4'h7: key = 4'hB;
            4'h8: key = 4'h7;
            4'h9: key = 4'h8;
            4'hA: key = 4'h9;
            4'hB: key = 4'hC;
            4'hC: key = 4'h0;
            4'hD: key = 4'hF;
            4'hE: key = 4'hE;
            4'hF: key = 4'hD;
            default: key = 4'h0;
        endcase
        return key;
    endfunction

    // Columns are active-low; the lowest low column index wins.
    function automatic logic [1:0] low_col(input logic [3:0] cols);
        logic [1:0] idx;
        casez (cols)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/col_synchronizer.sv
// Two-flop synchronizer for the four active-low keypad column returns.
module col_synchronizer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] async_i,
    output logic [3:0] sync_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // NOTE: reset to all-ones so an idle (pulled-up) keypad is seen during and after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: row-multiplexed scan, press/release debounce,
// one-cycle accept strobe and a four-key history shift register.
module hex_keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  colSense,
    input  logic        clearDigits,
    output logic [3:0]  rowDrive,
    output logic [3:0]  keyVal,
    output logic        keyValid,
    output logic        keyHeld,
    output logic [15:0] digits
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_GOAL = MW'(DEBOUNCE_SCANS);

    logic [3:0]    col_s;
    state_e        state_q, state_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [MW-1:0] match_q, match_d, match_inc;
    logic [1:0]    row_q, row_d;
    logic [1:0]    cand_col_q, cand_col_d;
    logic [3:0]    key_val_q, key_val_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [15:0]   digits_q, digits_d;
    logic          sample, any_low, accept;
    logic [1:0]    col_now;

    col_synchronizer u_col_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (colSense),
        .sync_o  (col_s)
    );

    assign sample    = (dwell_q == DWELL_LAST);
    assign any_low   = (col_s != 4'hF);
    assign col_now   = low_col(col_s);
    assign match_inc = match_q + 1'b1;

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        dwell_d     = sample ? '0 : dwell_q + 1'b1;
        match_d     = match_q;
        row_d       = row_q;
        cand_col_d  = cand_col_q;
        key_val_d   = key_val_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        digits_d    = digits_q;
        accept      = 1'b0;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (!any_low) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        cand_col_d = col_now;
                        match_d    = MW'(1);
                        if (DEBOUNCE_SCANS == 1) accept = 1'b1;
                        else                     state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && col_now == cand_col_q) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_GOAL) accept = 1'b1;
                    end else begin
                        match_d = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    // In HELD the match counter counts consecutive released samples.
                    if (any_low) begin
                        match_d = '0;
                    end else if (match_inc == MATCH_GOAL) begin
                        match_d    = '0;
                        key_held_d = 1'b0;
                        state_d    = SCAN;
                    end else begin
                        match_d = match_inc;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (accept) begin
            state_d     = HELD;
            match_d     = '0;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            key_val_d   = key_map(row_q, cand_col_d);
            digits_d    = {digits_q[11:0], key_val_d};
        end

        if (clearDigits) digits_d = accept ? {12'h000, key_val_d} : 16'h0000;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            match_q     <= '0;
            row_q       <= 2'd0;
            cand_col_q  <= 2'd0;
            key_val_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            match_q     <= match_d;
            row_q       <= row_d;
            cand_col_q  <= cand_col_d;
            key_val_q   <= key_val_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    assign rowDrive = ~(4'b0001 << row_q);
    assign keyVal   = key_val_q;
    assign keyValid = key_valid_q;
    assign keyHeld  = key_held_q;
    assign digits   = digits_q;

endmodule
